// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack unit: opcode encodings and control states.
package rpn_pkg;

  localparam logic [1:0] OP_MLT  = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_PUSH = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/rpn_seq_mult.sv
// Shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset (aborts a multiply)
//   start        - load a/b and begin; ignored fields reloaded on every start
//   a, b         - WIDTH-bit unsigned operands
//   done         - high during the WIDTH-th cycle after start
//   product      - full 2*WIDTH-bit result, valid while done is high
module rpn_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The final partial product is folded in combinationally so the caller can
  // commit on the same edge that retires the last iteration.
  assign done     = busy_q && (cnt_q == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH);
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_stack_unit.sv
// RPN calculator stack: PUSH/POP/ADD/MLT on a DEPTH-entry stack of WIDTH-bit words.
// Build option: define RPN_SEQ_MUL_EN to use a WIDTH-cycle shift-add multiplier for
// MLT (op_ready drops while it runs); otherwise MLT is single-cycle.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   op_valid, op_code  - operation request and select (0 MLT, 1 ADD, 2 POP, 3 PUSH)
//   din                - PUSH operand
//   op_ready           - operation can be accepted this cycle (registered)
//   top, dval, size    - stack[0], non-empty flag, element count
//   stack_ovf          - set by a PUSH onto a full stack
//   arith_ovf          - carry out of ADD / high half non-zero on MLT
module rpn_stack_unit
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [1:0]                 op_code,
  input  logic [WIDTH-1:0]           din,
  output logic                       op_ready,
  output logic [WIDTH-1:0]           top,
  output logic                       dval,
  output logic [$clog2(DEPTH+1)-1:0] size,
  output logic                       stack_ovf,
  output logic                       arith_ovf
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [SW-1:0]    size_q, size_d;
  logic             sovf_q, sovf_d;
  logic             aovf_q, aovf_d;
  state_e           state_q, state_d;
  logic             ready_q;

  logic             bin_commit;
  logic [WIDTH-1:0] bin_res;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] mul_product;

  assign sum = {1'b0, stack_q[0]} + {1'b0, stack_q[1]};

`ifdef RPN_SEQ_MUL_EN
  logic mul_start;
  logic mul_done;

  rpn_seq_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (stack_q[0]),
    .b      (stack_q[1]),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  assign mul_product = {{WIDTH{1'b0}}, stack_q[0]} * {{WIDTH{1'b0}}, stack_q[1]};
`endif

  always_comb begin
    stack_d    = stack_q;
    size_d     = size_q;
    sovf_d     = sovf_q;
    aovf_d     = aovf_q;
    state_d    = state_q;
    bin_commit = 1'b0;
    bin_res    = '0;
`ifdef RPN_SEQ_MUL_EN
    mul_start  = 1'b0;
`endif

    if (state_q == ST_IDLE) begin
      if (op_valid) begin
        unique case (op_code)
          OP_PUSH: begin
            for (int i = DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
            stack_d[0] = din;
            aovf_d     = 1'b0;
            if (size_q == SW'(DEPTH)) begin
              sovf_d = 1'b1;
            end else begin
              sovf_d = 1'b0;
              size_d = size_q + SW'(1);
            end
          end
          OP_POP: begin
            if (size_q != '0) begin
              for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
              stack_d[DEPTH-1] = '0;
              size_d = size_q - SW'(1);
              sovf_d = 1'b0;
              aovf_d = 1'b0;
            end
          end
          OP_ADD: begin
            if (size_q > SW'(1)) begin
              bin_commit = 1'b1;
              bin_res    = sum[WIDTH-1:0];
              aovf_d     = sum[WIDTH];
            end
          end
          OP_MLT: begin
            if (size_q == SW'(1)) begin
              stack_d[0] = '0;
              aovf_d     = 1'b0;
            end else if (size_q > SW'(1)) begin
`ifdef RPN_SEQ_MUL_EN
              mul_start = 1'b1;
              state_d   = ST_MUL;
`else
              bin_commit = 1'b1;
              bin_res    = mul_product[WIDTH-1:0];
              aovf_d     = |mul_product[2*WIDTH-1:WIDTH];
`endif
            end
          end
        endcase
      end
    end else begin
`ifdef RPN_SEQ_MUL_EN
      // Operands stay put in stack_q while the multiplier runs.
      if (mul_done) begin
        bin_commit = 1'b1;
        bin_res    = mul_product[WIDTH-1:0];
        aovf_d     = |mul_product[2*WIDTH-1:WIDTH];
        state_d    = ST_IDLE;
      end
`else
      state_d = ST_IDLE;
`endif
    end

    // Binary ops replace the top two entries with one result.
    if (bin_commit) begin
      stack_d[0] = bin_res;
      for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
      stack_d[DEPTH-1] = '0;
      size_d = size_q - SW'(1);
      sovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      size_q  <= '0;
      sovf_q  <= 1'b0;
      aovf_q  <= 1'b0;
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      stack_q <= stack_d;
      size_q  <= size_d;
      sovf_q  <= sovf_d;
      aovf_q  <= aovf_d;
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign op_ready  = ready_q;
  assign top       = stack_q[0];
  assign dval      = (size_q != '0);
  assign size      = size_q;
  assign stack_ovf = sovf_q;
  assign arith_ovf = aovf_q;

endmodule

// File: tb/tb_rpn_stack_unit.sv
// Directed self-checking bench for rpn_stack_unit (WIDTH=8, DEPTH=4).
// Works with or without RPN_SEQ_MUL_EN defined.
module tb_rpn_stack_unit;

  localparam logic [1:0] MLT = 2'd0, ADD = 2'd1, POP = 2'd2, PUSH = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op_code = 2'd0;
  logic [7:0] din = 8'd0;
  logic       op_ready;
  logic [7:0] top;
  logic       dval;
  logic [2:0] size;
  logic       stack_ovf;
  logic       arith_ovf;

  int passed = 0;
  int total  = 0;

  rpn_stack_unit #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .din      (din),
    .op_ready (op_ready),
    .top      (top),
    .dval     (dval),
    .size     (size),
    .stack_ovf(stack_ovf),
    .arith_ovf(arith_ovf)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one op, wait for acceptance and for op_ready to return (both bounded).
  task automatic do_op(input logic [1:0] code, input logic [7:0] data);
    int n;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    din      = data;
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      total++;
      $display("FAIL op_timeout op_ready=%0b want 1", op_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({top, size, dval, stack_ovf, arith_ovf, op_ready} !== {8'd0, 3'd0, 4'b0001})
      $display("FAIL reset_state got top=%0d size=%0d dval=%0b sovf=%0b aovf=%0b rdy=%0b want 0,0,0,0,0,1",
               top, size, dval, stack_ovf, arith_ovf, op_ready);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    do_op(PUSH, 8'd3);
    do_op(PUSH, 8'd5);
    do_op(ADD, 8'd0);
    total++; if (top !== 8'd8) $display("FAIL add_top got %0d want 8", top); else passed++;
    total++; if ({size, arith_ovf, dval} !== {3'd1, 1'b0, 1'b1})
      $display("FAIL add_flags got size=%0d aovf=%0b dval=%0b want 1,0,1", size, arith_ovf, dval);
    else passed++;
    // ADD with one element is a no-op.
    do_op(ADD, 8'd0);
    total++; if ({top, size} !== {8'd8, 3'd1})
      $display("FAIL add_single got top=%0d size=%0d want 8,1", top, size);
    else passed++;
  endtask

  task automatic test_add_ovf();
    do_reset();
    do_op(PUSH, 8'd200);
    do_op(PUSH, 8'd100);
    do_op(ADD, 8'd0);
    total++; if ({top, size, arith_ovf} !== {8'd44, 3'd1, 1'b1})
      $display("FAIL add_ovf got top=%0d size=%0d aovf=%0b want 44,1,1", top, size, arith_ovf);
    else passed++;
    do_op(PUSH, 8'd1);
    total++; if ({size, arith_ovf} !== {3'd2, 1'b0})
      $display("FAIL push_clr_aovf got size=%0d aovf=%0b want 2,0", size, arith_ovf);
    else passed++;
  endtask

  task automatic test_stack_ovf();
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(PUSH, 8'(i));
    total++; if ({size, stack_ovf} !== {3'd4, 1'b0})
      $display("FAIL full_no_ovf got size=%0d sovf=%0b want 4,0", size, stack_ovf);
    else passed++;
    do_op(PUSH, 8'd5);
    total++; if ({top, size, stack_ovf} !== {8'd5, 3'd4, 1'b1})
      $display("FAIL stack_ovf got top=%0d size=%0d sovf=%0b want 5,4,1", top, size, stack_ovf);
    else passed++;
    do_op(POP, 8'd0);
    total++; if ({top, size, stack_ovf} !== {8'd4, 3'd3, 1'b0})
      $display("FAIL pop_after_ovf got top=%0d size=%0d sovf=%0b want 4,3,0", top, size, stack_ovf);
    else passed++;
    do_op(POP, 8'd0);
    total++; if (top !== 8'd3) $display("FAIL pop2 got %0d want 3", top); else passed++;
    do_op(POP, 8'd0);
    total++; if ({top, size} !== {8'd2, 3'd1})
      $display("FAIL pop3 got top=%0d size=%0d want 2,1", top, size);
    else passed++;
    do_op(POP, 8'd0);
    total++; if ({top, size, dval} !== {8'd0, 3'd0, 1'b0})
      $display("FAIL pop_empty got top=%0d size=%0d dval=%0b want 0,0,0", top, size, dval);
    else passed++;
  endtask

  task automatic test_mult();
    int low;
    do_reset();
    do_op(PUSH, 8'd16);
    do_op(PUSH, 8'd20);
`ifdef RPN_SEQ_MUL_EN
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = MLT;
    @(negedge clk);
    // Second request held throughout the multiply.
    op_code = PUSH;
    din     = 8'd9;
    low = 0;
    while (!op_ready && low < 40) begin
      if (low == 3) begin
        total++; if ({top, size, arith_ovf} !== {8'd20, 3'd2, 1'b0})
          $display("FAIL mul_hold got top=%0d size=%0d aovf=%0b want 20,2,0", top, size, arith_ovf);
        else passed++;
      end
      low++;
      @(negedge clk);
    end
    total++; if (low !== 8) $display("FAIL mul_busy_cycles got %0d want 8", low); else passed++;
    total++; if ({top, size, arith_ovf} !== {8'd64, 3'd1, 1'b1})
      $display("FAIL mul_result got top=%0d size=%0d aovf=%0b want 64,1,1", top, size, arith_ovf);
    else passed++;
    @(negedge clk);
    op_valid = 1'b0;
    total++; if ({top, size, arith_ovf} !== {8'd9, 3'd2, 1'b0})
      $display("FAIL held_push got top=%0d size=%0d aovf=%0b want 9,2,0", top, size, arith_ovf);
    else passed++;
`else
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = MLT;
    @(negedge clk);
    op_valid = 1'b0;
    total++; if (op_ready !== 1'b1) $display("FAIL comb_mul_ready got %0b want 1", op_ready);
    else passed++;
    total++; if ({top, size, arith_ovf} !== {8'd64, 3'd1, 1'b1})
      $display("FAIL mul_result got top=%0d size=%0d aovf=%0b want 64,1,1", top, size, arith_ovf);
    else passed++;
`endif
    do_op(PUSH, 8'd3);
    do_op(MLT, 8'd0);
    total++; if ({top, size, arith_ovf} !== {8'd192, 3'd1, 1'b0})
      $display("FAIL mul_small got top=%0d size=%0d aovf=%0b want 192,1,0", top, size, arith_ovf);
    else passed++;
  endtask

  task automatic test_empty();
    do_reset();
    do_op(POP, 8'd0);
    do_op(ADD, 8'd0);
    do_op(MLT, 8'd0);
    total++; if ({top, size, dval, stack_ovf, arith_ovf} !== {8'd0, 3'd0, 3'b000})
      $display("FAIL empty_ops got top=%0d size=%0d dval=%0b sovf=%0b aovf=%0b want 0,0,0,0,0",
               top, size, dval, stack_ovf, arith_ovf);
    else passed++;
    do_op(PUSH, 8'd7);
    do_op(MLT, 8'd0);
    total++; if ({top, size, dval} !== {8'd0, 3'd1, 1'b1})
      $display("FAIL mul_single got top=%0d size=%0d dval=%0b want 0,1,1", top, size, dval);
    else passed++;
  endtask

  task automatic test_reset_during_mul();
`ifdef RPN_SEQ_MUL_EN
    do_reset();
    do_op(PUSH, 8'd9);
    do_op(PUSH, 8'd9);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = MLT;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({top, size, dval, stack_ovf, arith_ovf, op_ready} !== {8'd0, 3'd0, 4'b0001})
      $display("FAIL mul_abort_reset got top=%0d size=%0d rdy=%0b want 0,0,1", top, size, op_ready);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    total++; if ({top, size, op_ready} !== {8'd0, 3'd0, 1'b1})
      $display("FAIL mul_no_commit got top=%0d size=%0d rdy=%0b want 0,0,1", top, size, op_ready);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_ovf();
    test_stack_ovf();
    test_mult();
    test_empty();
    test_reset_during_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rpn_stack_unit.md
RPN_STACK_UNIT -- requirements
Module: rpn_stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/element width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, stack capacity in elements (>=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op_code  input  2  operation select: 0 MLT, 1 ADD, 2 POP, 3 PUSH.
REQ-007 SHALL have port din  input  WIDTH  operand for PUSH.
REQ-008 SHALL have port op_ready  output  1  high when an operation can be accepted.
REQ-009 SHALL have port top  output  WIDTH  stack[0] (display value).
REQ-010 SHALL have port dval  output  1  high when size != 0.
REQ-011 SHALL have port size  output  $clog2(DEPTH+1)  element count.
REQ-012 SHALL have port stack_ovf  output  1  sticky stack-overflow flag.
REQ-013 SHALL have port arith_ovf  output  1  arithmetic-overflow flag.

Function
REQ-014 SHALL accept an operation on a rising edge where op_valid && op_ready; no other edge changes the stack.
REQ-015 SHALL apply every non-MLT op in one cycle; outputs reflect it the cycle after acceptance.
REQ-016 PUSH: shift stack up, stack[0]=din, size+1; clear both flags.
REQ-017 PUSH when size==DEPTH: shift anyway (bottom element lost), size stays DEPTH, set stack_ovf, clear arith_ovf.
REQ-018 POP when size>=1: shift stack down, stack[DEPTH-1]=0, size-1; clear both flags.
REQ-019 POP, ADD, MLT when size==0: no state change, flags unchanged.
REQ-020 ADD when size==1: no state change, flags unchanged.
REQ-021 ADD when size>=2: stack[0]=(stack[0]+stack[1]) mod 2^WIDTH, shift stack[2..] down one, size-1; arith_ovf=carry out; clear stack_ovf.
REQ-022 MLT when size==1: stack[0]=0, size unchanged; clear arith_ovf.
REQ-023 MLT when size>=2: stack[0]=low WIDTH bits of unsigned product, shift stack[2..] down, size-1; arith_ovf=1 iff high WIDTH bits nonzero; clear stack_ovf.
REQ-024 SHALL hold op_ready high in state IDLE and low in state MUL; op_ready SHALL NOT depend combinationally on op_valid.
REQ-025 State machine: IDLE -> MUL on accepted MLT with size>=2 (sequential mode only); MUL -> IDLE on final iteration, committing result that edge.
REQ-026 top, size, flags SHALL hold pre-MLT values while in MUL.

Reset
REQ-027 reset SHALL immediately force all elements 0, size 0, top 0, dval 0, stack_ovf 0, arith_ovf 0, state IDLE, op_ready 1.
REQ-028 reset during MUL SHALL abort the multiply with no partial commit.

Configuration
REQ-029 Macro RPN_SEQ_MUL_EN defined: MLT with size>=2 uses shift-add multiplier, op_ready low for exactly WIDTH cycles after acceptance, result visible the cycle op_ready returns high.
REQ-030 Macro RPN_SEQ_MUL_EN undefined: MLT completes in one cycle like ADD; state MUL unreachable, op_ready constant 1 outside reset.

Structure
REQ-031 Package rpn_pkg SHALL hold op_code constants (OP_MLT, OP_ADD, OP_POP, OP_PUSH) and state enum (ST_IDLE, ST_MUL).
REQ-032 Sequential multiplier SHALL be sub-module rpn_seq_mult (start, a, b -> done, product[2*WIDTH-1:0]), instantiated only under RPN_SEQ_MUL_EN.

Verification (WIDTH=8, DEPTH=4)
REQ-033 PUSH 3, PUSH 5, ADD -> top=8, size=1, arith_ovf=0, dval=1.
REQ-034 PUSH 200, PUSH 100, ADD -> top=44, size=1, arith_ovf=1; then PUSH 1 -> arith_ovf=0, size=2.
REQ-035 PUSH 1,2,3,4,5 -> size=4, top=5, stack_ovf=1, stack=[5,4,3,2]; then POP -> top=4, size=3, stack_ovf=0.
REQ-036 PUSH 16, PUSH 20, MLT -> top=64, arith_ovf=1, size=1; with RPN_SEQ_MUL_EN, op_ready low exactly 8 cycles and a second op_valid held meanwhile is accepted only after.
REQ-037 Empty stack: POP, ADD, MLT -> size=0, top=0, dval=0, flags unchanged; then PUSH 7, MLT -> top=0, size=1.
REQ-038 With RPN_SEQ_MUL_EN: PUSH 9, PUSH 9, MLT, assert reset at cycle 3 of MUL -> all outputs reset values, op_ready=1, no result committed.
